// File: rtl/ballot_session_ctrl.sv
// ballot_session_ctrl
// Per-voter session controller ahead of the vote logger/counter. Sequences the
// poll phases and grants exactly one debounced, qualified vote per officer
// authorisation, presented as a single-cycle strobe with the chosen candidate.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   open_poll    1 = poll open
//   voter_auth   officer authorisation, sampled every cycle
//   mode         0 = voting, 1 = results display
//   candidate    one-hot candidate selection
//   button       cast button level
//   vote_valid   one-cycle strobe to the vote logger
//   vote_sel     encoded candidate index of the latched selection
//   vote_onehot  latched one-hot candidate
//   busy         session in progress (ARMED, HOLD, ACK)
//   ack_led      acknowledge indicator after a logged vote
//   error        invalid candidate pattern seen at a press (sticky per session)
//   timeout      one-cycle pulse when a session expires
//   total_votes  votes granted since reset, saturating
//   state        current FSM state code
//
// state   | meaning
// --------+------------------------------------------------------------
// CLOSED  | poll closed, nothing accepted
// IDLE    | poll open, waiting for an officer authorisation
// ARMED   | voter authorised, waiting for a valid press
// HOLD    | press seen, waiting for it to stay stable long enough
// ACK     | vote logged; ack_led period, then wait for button release
// RESULTS | results display, no votes accepted
module ballot_session_ctrl #(
    parameter int HOLD_CYCLES    = 4,
    parameter int ACK_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TOTAL_W        = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               open_poll,
    input  logic               voter_auth,
    input  logic               mode,
    input  logic [3:0]         candidate,
    input  logic               button,
    output logic               vote_valid,
    output logic [1:0]         vote_sel,
    output logic [3:0]         vote_onehot,
    output logic               busy,
    output logic               ack_led,
    output logic               error,
    output logic               timeout,
    output logic [TOTAL_W-1:0] total_votes,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_CLOSED  = 3'd0,
        S_IDLE    = 3'd1,
        S_ARMED   = 3'd2,
        S_HOLD    = 3'd3,
        S_ACK     = 3'd4,
        S_RESULTS = 3'd5
    } state_t;

    // All timers count down and fire on reaching zero.
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);
    localparam int ACK_W  = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES - 1) : 1;

    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ACK_W-1:0]  ACK_LOAD = ACK_W'(ACK_CYCLES - 1);
    // The press cycle that enters HOLD already counts as the first stable
    // cycle; HOLD_CYCLES=1 still needs one more stable cycle to qualify.
    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        HOLD_W'((HOLD_CYCLES > 1) ? (HOLD_CYCLES - 2) : 0);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [ACK_W-1:0]   ack_q, ack_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [3:0]         onehot_d;
    logic [1:0]         sel_d;
    logic               err_d;
    logic               valid_d;
    logic               led_d;
    logic               timeout_d;
    logic               busy_d;
    logic [TOTAL_W-1:0] total_d;
    logic               cand_one_hot;

    assign cand_one_hot = (candidate != 4'd0) &&
                          ((candidate & 4'(candidate - 4'd1)) == 4'd0);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        ack_d     = ack_q;
        hold_d    = hold_q;
        onehot_d  = vote_onehot;
        sel_d     = vote_sel;
        err_d     = error;
        total_d   = total_votes;
        valid_d   = 1'b0;
        led_d     = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            S_CLOSED: begin
                if (mode)           state_d = S_RESULTS;
                else if (open_poll) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (mode)            state_d = S_RESULTS;
                else if (!open_poll) state_d = S_CLOSED;
                else if (voter_auth) begin
                    state_d  = S_ARMED;
                    tmr_d    = TMR_LOAD;
                    hold_d   = '0;
                    err_d    = 1'b0;
                    onehot_d = 4'd0;
                    sel_d    = 2'd0;
                end
            end
            S_ARMED: begin
                if (!open_poll) state_d = S_CLOSED;
                else if (tmr_q == '0) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                    if (button) begin
                        if (cand_one_hot) begin
                            state_d  = S_HOLD;
                            onehot_d = candidate;
                            sel_d    = {candidate[3] | candidate[2],
                                        candidate[3] | candidate[1]};
                            hold_d   = HOLD_LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!open_poll) state_d = S_CLOSED;
                else if (tmr_q == '0) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    // Session timer keeps running across a bounce back to ARMED.
                    tmr_d = tmr_q - 1'b1;
                    if (!button || (candidate != vote_onehot)) begin
                        state_d = S_ARMED;
                        hold_d  = '0;
                    end else if (hold_q == '0) begin
                        state_d = S_ACK;
                        valid_d = 1'b1;
                        led_d   = 1'b1;
                        ack_d   = ACK_LOAD;
                        if (!(&total_votes)) total_d = total_votes + 1'b1;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
            S_ACK: begin
                // Poll closing here does not cancel the vote; exit is normal.
                if (ack_q != '0) begin
                    ack_d = ack_q - 1'b1;
                    led_d = 1'b1;
                end else if (!button) begin
                    state_d = S_IDLE;
                end
            end
            S_RESULTS: begin
                if (!mode) state_d = S_CLOSED;
            end
            default: state_d = S_CLOSED;
        endcase

        busy_d = (state_d == S_ARMED) || (state_d == S_HOLD) ||
                 (state_d == S_ACK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_CLOSED;
            tmr_q       <= '0;
            ack_q       <= '0;
            hold_q      <= '0;
            vote_valid  <= 1'b0;
            vote_sel    <= 2'd0;
            vote_onehot <= 4'd0;
            busy        <= 1'b0;
            ack_led     <= 1'b0;
            error       <= 1'b0;
            timeout     <= 1'b0;
            total_votes <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            ack_q       <= ack_d;
            hold_q      <= hold_d;
            vote_valid  <= valid_d;
            vote_sel    <= sel_d;
            vote_onehot <= onehot_d;
            busy        <= busy_d;
            ack_led     <= led_d;
            error       <= err_d;
            timeout     <= timeout_d;
            total_votes <= total_d;
        end
    end

    assign state = state_q;

endmodule
